// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
//   Shared types for the IF-stage PC generator and its fetch buffer.
//   - RESET_PC_DEFAULT : PC of the first fetch after reset
//   - if_state_t       : fetch-bus state (IDLE / WAIT / CANCEL)
//   - fetch_entry_t    : one {pc, inst} pair handed to ID
// -----------------------------------------------------------------------------
package if_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

    // IDLE   : nothing outstanding on the bus
    // WAIT   : one right-path fetch outstanding
    // CANCEL : one wrong-path fetch outstanding; its data is discarded
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        CANCEL = 2'd2
    } if_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buf.sv
// -----------------------------------------------------------------------------
// if_fetch_buf
//   Circular FIFO of fetch_entry_t between the fetch bus and ID.
//   Synchronous active-low reset; flush empties the FIFO in one cycle and
//   wins over push/pop in the same cycle.
//   Ports:
//     clk, rst_n     : clock, synchronous active-low reset
//     push, wr_data  : write one entry (ignored when full)
//     pop            : drop the head entry (ignored when empty)
//     flush          : discard all entries
//     head           : head entry, zero when empty
//     count          : number of valid entries (0..DEPTH)
//     empty, full    : occupancy flags
// -----------------------------------------------------------------------------
module if_fetch_buf
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  fetch_entry_t             wr_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          wr_en;
    logic          rd_en;

    // Explicit wrap so a non-power-of-two depth would still be correct.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign head  = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; count alone decides
    // which slots hold valid data, and head is forced to zero when empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/if_pc_gen.sv
// -----------------------------------------------------------------------------
// if_pc_gen
//   IF-stage PC generator and fetch buffer. Offers if_pc to the predictor and
//   the fetch bus, advances to pred_target when a fetch is accepted, applies
//   ID redirects (discarding wrong-path fetches) and buffers {pc, inst} pairs
//   toward ID.
//   Build option: define IF_PC_GEN_BYPASS_EN to forward a response straight
//   to ID in its arrival cycle when the buffer is empty and ID accepts.
//   Ports:
//     cpu_clk, cpu_rstn           : clock, synchronous active-low reset
//     if_pc / pred_target         : current fetch PC / predictor's next PC
//     redirect_valid, redirect_pc : misprediction redirect from ID
//     inst_req, inst_addr         : fetch request (inst_addr == if_pc)
//     inst_addr_ok                : request accepted this cycle
//     inst_data_ok, inst_rdata    : fetch response
//     id_allowin                  : ID accepts the head this cycle
//     if_to_id_valid/_pc/_inst    : head entry toward ID
// -----------------------------------------------------------------------------
module if_pc_gen
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    output logic [31:0] if_pc,
    input  logic [31:0] pred_target,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        id_allowin,
    output logic        if_to_id_valid,
    output logic [31:0] if_to_id_pc,
    output logic [31:0] if_to_id_inst
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    if_state_t     state;
    if_state_t     state_n;
    logic [31:0]   if_pc_n;
    logic [31:0]   req_pc;
    logic [31:0]   req_pc_n;
    logic          fetch_en;

    logic [CW-1:0] count;
    logic          buf_empty;
    logic          buf_full;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    logic          live_resp;
    logic          has_credit;
    logic          accept;
    logic          push;
    logic          pop;
    logic          bypass;

    // A right-path response is only meaningful in WAIT; in CANCEL it is junk.
    assign live_resp = (state == WAIT) & inst_data_ok;

    // Reserve a slot for the live outstanding fetch so the buffer can never
    // be pushed while full.
    assign has_credit = ~buf_full
                      & ((int'(count) + int'(state == WAIT)) < BUF_DEPTH);

    // fetch_en holds the bus quiet during reset and the release cycle, so
    // the first request appears the cycle after cpu_rstn goes high.
    assign inst_req  = fetch_en & ((state == IDLE) | live_resp) & has_credit;
    assign inst_addr = if_pc;
    assign accept    = inst_req & inst_addr_ok;

`ifdef IF_PC_GEN_BYPASS_EN
    assign bypass = buf_empty & live_resp & ~redirect_valid & id_allowin;
`else
    assign bypass = 1'b0;
`endif

    assign push       = live_resp & ~redirect_valid & ~bypass;
    assign pop        = ~buf_empty & id_allowin;
    assign push_entry = '{pc: req_pc, inst: inst_rdata};

    assign if_to_id_valid = ~buf_empty | bypass;
    assign if_to_id_pc    = bypass ? req_pc     : head.pc;
    assign if_to_id_inst  = bypass ? inst_rdata : head.inst;

    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_n  = state;
        if_pc_n  = if_pc;
        req_pc_n = req_pc;
        if (redirect_valid) begin
            if_pc_n = redirect_pc;
            // Anything still in flight after this edge belongs to the wrong
            // path: either the old WAIT fetch or one accepted right now.
            if (((state == WAIT || state == CANCEL) && !inst_data_ok) || accept)
                state_n = CANCEL;
            else
                state_n = IDLE;
        end else begin
            unique case (state)
                IDLE, WAIT: begin
                    if (accept) begin
                        req_pc_n = if_pc;
                        if_pc_n  = pred_target;
                        state_n  = WAIT;
                    end else if (live_resp) begin
                        state_n  = IDLE;
                    end
                end
                CANCEL: begin
                    if (inst_data_ok) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn) begin
            state    <= IDLE;
            if_pc    <= RESET_PC;
            req_pc   <= '0;
            fetch_en <= 1'b0;
        end else begin
            state    <= state_n;
            if_pc    <= if_pc_n;
            req_pc   <= req_pc_n;
            fetch_en <= 1'b1;
        end
    end

    if_fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (cpu_clk),
        .rst_n   (cpu_rstn),
        .push    (push),
        .wr_data (push_entry),
        .pop     (pop),
        .flush   (redirect_valid),
        .head    (head),
        .count   (count),
        .empty   (buf_empty),
        .full    (buf_full)
    );

endmodule

// File: tb/tb_if_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_if_pc_gen
//   Self-checking bench for if_pc_gen. A randomised SRAM-like slave serves
//   fetches; the reference model is the program-order PC stream: starting at
//   RESET_PC (or a redirect target), each instruction delivered to ID must be
//   the predictor's successor of the previous one, with inst = inst_of(pc).
// -----------------------------------------------------------------------------
module tb_if_pc_gen;

    localparam logic [31:0] RESET_PC  = 32'h1c00_0000;
    localparam int          BUF_DEPTH = 2;

    logic        cpu_clk = 1'b0;
    logic        cpu_rstn;
    logic [31:0] if_pc;
    logic [31:0] pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        id_allowin;
    logic        if_to_id_valid;
    logic [31:0] if_to_id_pc;
    logic [31:0] if_to_id_inst;

    if_pc_gen #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .cpu_clk        (cpu_clk),
        .cpu_rstn       (cpu_rstn),
        .if_pc          (if_pc),
        .pred_target    (pred_target),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .id_allowin     (id_allowin),
        .if_to_id_valid (if_to_id_valid),
        .if_to_id_pc    (if_to_id_pc),
        .if_to_id_inst  (if_to_id_inst)
    );

    always #5 cpu_clk = ~cpu_clk;

    int n_cmp = 0;
    int n_err = 0;

    // stimulus knobs
    int  pred_mode = 0;
    int  ok_pct    = 100;
    int  lat_min   = 1;
    int  lat_max   = 1;
    int  allow_pct = 100;
    bit  rst_val   = 1'b0;
    bit  redir_now = 1'b0;
    logic [31:0] redir_tgt = 32'h0;
    bit  force_resp  = 1'b0;
    bit  collide_arm = 1'b0;
    bit  collide_hit = 1'b0;

    // slave state: at most one fetch pending
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_wait = 0;

    // reference stream
    logic [31:0] exp_pc = RESET_PC;
    int          n_deliv = 0;
    logic [31:0] deliv_q [$];
    logic [31:0] acc_q   [$];

    // The "program": what the predictor says follows pc.
    function automatic logic [31:0] pred_fn(input int mode, input logic [31:0] pc);
        case (mode)
            1:       return (pc == 32'h1c00_0004) ? 32'h1c00_0100 : pc + 32'd4;
            2:       return (pc[5:2] == 4'hA) ? pc + 32'h80 : pc + 32'd4;
            default: return pc + 32'd4;
        endcase
    endfunction

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h3c5a_9600;
    endfunction

    function automatic logic [31:0] deliv_at(input int i);
        return (i < deliv_q.size()) ? deliv_q[i] : 32'hdead_dead;
    endfunction

    // One clock cycle: drive inputs after the falling edge, sample before the
    // rising edge, then advance slave and stream model for that rising edge.
    task automatic step();
        bit dok;
        bit aok;
        bit acc;
        @(negedge cpu_clk);
        cpu_rstn     = rst_val;
        dok          = pend && (pend_wait == 0 || force_resp);
        inst_data_ok = dok;
        inst_rdata   = dok ? inst_of(pend_addr) : $urandom();
        aok          = rst_val && (int'($urandom_range(99, 0)) < ok_pct);
        inst_addr_ok = aok;
        pred_target  = pred_fn(pred_mode, if_pc);
        #1;
        // inst_req does not depend on redirect/allowin, so it can be peeked.
        if (collide_arm && rst_val && dok && inst_req && aok) begin
            redir_now   = 1'b1;
            collide_arm = 1'b0;
            collide_hit = 1'b1;
        end
        redirect_valid = redir_now;
        redirect_pc    = redir_now ? redir_tgt : $urandom();
        id_allowin     = !redir_now && (int'($urandom_range(99, 0)) < allow_pct);
        #1;
        if (rst_val) begin
            if (inst_req) begin
                n_cmp++;
                if (inst_addr !== if_pc) begin
                    n_err++;
                    $display("FAIL addr_is_pc: inst_addr=%h if_pc=%h", inst_addr, if_pc);
                end
                n_cmp++;
                if (pend && !dok) begin
                    n_err++;
                    $display("FAIL one_outstanding: inst_req=1 while fetch %h pending", pend_addr);
                end
            end
            if (if_to_id_valid && id_allowin) begin
                n_cmp++;
                if (if_to_id_pc !== exp_pc || if_to_id_inst !== inst_of(exp_pc)) begin
                    n_err++;
                    $display("FAIL id_stream: got pc=%h inst=%h, want pc=%h inst=%h",
                             if_to_id_pc, if_to_id_inst, exp_pc, inst_of(exp_pc));
                end
                deliv_q.push_back(if_to_id_pc);
                n_deliv++;
                exp_pc = pred_fn(pred_mode, exp_pc);
            end
        end
        acc = rst_val && inst_req && aok;
        if (dok) pend = 1'b0;
        else if (pend) pend_wait--;
        if (acc) begin
            pend      = 1'b1;
            pend_addr = inst_addr;
            pend_wait = int'($urandom_range(lat_max, lat_min)) - 1;
            acc_q.push_back(inst_addr);
        end
        if (!rst_val)      exp_pc = RESET_PC;
        else if (redir_now) exp_pc = redir_tgt;
        redir_now  = 1'b0;
        force_resp = 1'b0;
    endtask

    task automatic set_knobs(input int mode, input int ok, input int lmin,
                             input int lmax, input int allow);
        pred_mode = mode;
        ok_pct    = ok;
        lat_min   = lmin;
        lat_max   = lmax;
        allow_pct = allow;
    endtask

    task automatic apply_reset(input int cycles);
        pend        = 1'b0;
        force_resp  = 1'b0;
        redir_now   = 1'b0;
        collide_arm = 1'b0;
        rst_val     = 1'b0;
        repeat (cycles) step();
        rst_val = 1'b1;
        deliv_q.delete();
        acc_q.delete();
        n_deliv = 0;
        exp_pc  = RESET_PC;
    endtask

    task automatic run_until_deliv(input int target, input int budget, input string name);
        int b;
        b = 0;
        while (n_deliv < target && b < budget) begin
            step();
            b++;
        end
        n_cmp++;
        if (n_deliv < target) begin
            n_err++;
            $display("FAIL %s_timeout: delivered %0d, required %0d within %0d cycles",
                     name, n_deliv, target, budget);
        end
    endtask

    task automatic wait_pend(input int w, input int budget, input string name);
        int b;
        b = 0;
        while (!(pend && pend_wait == w) && b < budget) begin
            step();
            b++;
        end
        n_cmp++;
        if (!(pend && pend_wait == w)) begin
            n_err++;
            $display("FAIL %s_timeout: no accepted fetch within %0d cycles", name, budget);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b, required %b", name, got, want);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        set_knobs(0, 100, 1, 1, 100);
        apply_reset(3);
        check_word("rst_if_pc", if_pc, RESET_PC);
        check_bit ("rst_inst_req", inst_req, 1'b0);
        check_bit ("rst_valid", if_to_id_valid, 1'b0);
        check_word("rst_id_pc", if_to_id_pc, 32'h0);
        check_word("rst_id_inst", if_to_id_inst, 32'h0);
        step();
        check_bit("release_cycle_req", inst_req, 1'b0);
        step();
        check_bit("first_req", inst_req, 1'b1);
        check_word("first_addr", inst_addr, RESET_PC);
    endtask

    task automatic test_sequential();
        logic [31:0] want [3];
        want[0] = 32'h1c00_0000;
        want[1] = 32'h1c00_0004;
        want[2] = 32'h1c00_0008;
        set_knobs(0, 100, 1, 1, 100);
        apply_reset(2);
        run_until_deliv(3, 40, "seq");
        for (int i = 0; i < 3; i++) check_word("seq_pc", deliv_at(i), want[i]);
    endtask

    task automatic test_pred_jump();
        set_knobs(1, 100, 1, 1, 100);
        apply_reset(2);
        run_until_deliv(3, 40, "jump");
        check_word("jump_addr", (acc_q.size() > 2) ? acc_q[2] : 32'hdead_dead, 32'h1c00_0100);
        check_word("jump_pc0", deliv_at(0), 32'h1c00_0000);
        check_word("jump_pc1", deliv_at(1), 32'h1c00_0004);
        check_word("jump_pc2", deliv_at(2), 32'h1c00_0100);
    endtask

    task automatic test_redirect_wait();
        int base;
        set_knobs(0, 100, 3, 3, 100);
        apply_reset(2);
        run_until_deliv(1, 40, "rw_first");
        wait_pend(2, 40, "rw_accept");
        redir_tgt = 32'h1c00_0200;
        redir_now = 1'b1;
        step();
        step();
        check_bit("rw_flushed", if_to_id_valid, 1'b0);
        check_bit("rw_cancel_noreq", inst_req, 1'b0);
        base = n_deliv;
        run_until_deliv(base + 2, 40, "rw_next");
        check_word("rw_next_pc", deliv_at(base), 32'h1c00_0200);
        check_word("rw_next_pc2", deliv_at(base + 1), 32'h1c00_0204);
    endtask

    task automatic test_redirect_collide();
        int b;
        int base;
        set_knobs(0, 100, 1, 1, 100);
        apply_reset(2);
        run_until_deliv(2, 40, "rc_first");
        redir_tgt   = 32'h1c00_0200;
        collide_hit = 1'b0;
        collide_arm = 1'b1;
        b = 0;
        while (!collide_hit && b < 40) begin
            step();
            b++;
        end
        collide_arm = 1'b0;
        check_bit("rc_collision_seen", collide_hit, 1'b1);
        step();
        check_bit("rc_cancel_noreq", inst_req, 1'b0);
        check_bit("rc_flushed", if_to_id_valid, 1'b0);
        base = n_deliv;
        run_until_deliv(base + 1, 40, "rc_next");
        check_word("rc_next_pc", deliv_at(base), 32'h1c00_0200);
    endtask

    task automatic test_stall();
        int base;
        set_knobs(0, 100, 1, 1, 100);
        apply_reset(2);
        run_until_deliv(2, 40, "stall_first");
        allow_pct = 0;
        repeat (10) step();
        check_bit("stall_no_req", inst_req, 1'b0);
        check_bit("stall_valid", if_to_id_valid, 1'b1);
        ok_pct    = 0;
        allow_pct = 100;
        base      = n_deliv;
        repeat (6) step();
        n_cmp++;
        if (n_deliv - base != BUF_DEPTH) begin
            n_err++;
            $display("FAIL stall_buffered: drained %0d entries, required %0d", n_deliv - base, BUF_DEPTH);
        end
        ok_pct = 100;
        run_until_deliv(n_deliv + 4, 40, "stall_resume");
    endtask

    task automatic test_reset_mid_wait();
        int base;
        set_knobs(0, 100, 3, 3, 100);
        apply_reset(2);
        run_until_deliv(1, 40, "mr_first");
        wait_pend(2, 40, "mr_accept");
        rst_val    = 1'b0;
        force_resp = 1'b1;
        step();
        rst_val = 1'b1;
        step();
        check_word("mr_if_pc", if_pc, RESET_PC);
        check_bit ("mr_inst_req", inst_req, 1'b0);
        check_bit ("mr_valid", if_to_id_valid, 1'b0);
        check_word("mr_id_pc", if_to_id_pc, 32'h0);
        check_word("mr_id_inst", if_to_id_inst, 32'h0);
        base = n_deliv;
        run_until_deliv(base + 2, 40, "mr_restart");
        check_word("mr_restart_pc0", deliv_at(base), RESET_PC);
        check_word("mr_restart_pc1", deliv_at(base + 1), RESET_PC + 32'd4);
    endtask

    task automatic test_random();
        set_knobs(2, 70, 1, 3, 60);
        apply_reset(2);
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) ok_pct = int'($urandom_range(100, 30));
            if ($urandom_range(29, 0) == 0) begin
                redir_now = 1'b1;
                redir_tgt = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0
                          : {16'h1c00, 14'($urandom()), 2'b00};
            end
            step();
        end
        n_cmp++;
        if (n_deliv < 150) begin
            n_err++;
            $display("FAIL random_progress: delivered %0d, required at least 150", n_deliv);
        end
    endtask

    initial begin
        cpu_rstn       = 1'b0;
        pred_target    = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_addr_ok   = 1'b0;
        inst_data_ok   = 1'b0;
        inst_rdata     = 32'h0;
        id_allowin     = 1'b0;

        test_reset();
        test_sequential();
        test_pred_jump();
        test_redirect_wait();
        test_redirect_collide();
        test_stall();
        test_reset_mid_wait();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
